// File: rtl/hdmi_feed_pkg.sv
// Shared types and widths for the HDMI pixel feeder.
package hdmi_feed_pkg;

  localparam int unsigned PIX_W  = 24;
  localparam int unsigned STAT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_FILL,
    S_RUN
  } feed_state_e;

endpackage

// File: rtl/hdmi_pixel_feeder_if.sv
// Upstream pixel stream and transmitter-side signals of the HDMI pixel feeder.
// Statistics ports exist only when HDMI_FEED_STAT_EN is defined.
interface hdmi_pixel_feeder_if #(
  parameter int unsigned FIFO_DEPTH = 2048
);
  import hdmi_feed_pkg::*;

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [PIX_W-1:0] I_Up_Data;
  logic             I_Up_Valid;
  logic             O_Up_Ready;
  logic             O_Frame_Req;
  logic             I_Pixel_Active;
  logic             I_VGA_Sync;
  logic [PIX_W-1:0] O_Pixel_Data;
  logic             O_Underflow;
  logic [LVL_W-1:0] O_Fifo_Level;
`ifdef HDMI_FEED_STAT_EN
  logic [STAT_W-1:0] O_Underflow_Cnt;
  logic [STAT_W-1:0] O_Frame_Cnt;

  modport slave (
    input  I_Up_Data, I_Up_Valid, I_Pixel_Active, I_VGA_Sync,
    output O_Up_Ready, O_Frame_Req, O_Pixel_Data, O_Underflow, O_Fifo_Level,
    output O_Underflow_Cnt, O_Frame_Cnt
  );
  modport master (
    output I_Up_Data, I_Up_Valid, I_Pixel_Active, I_VGA_Sync,
    input  O_Up_Ready, O_Frame_Req, O_Pixel_Data, O_Underflow, O_Fifo_Level,
    input  O_Underflow_Cnt, O_Frame_Cnt
  );
`else
  modport slave (
    input  I_Up_Data, I_Up_Valid, I_Pixel_Active, I_VGA_Sync,
    output O_Up_Ready, O_Frame_Req, O_Pixel_Data, O_Underflow, O_Fifo_Level
  );
  modport master (
    output I_Up_Data, I_Up_Valid, I_Pixel_Active, I_VGA_Sync,
    input  O_Up_Ready, O_Frame_Req, O_Pixel_Data, O_Underflow, O_Fifo_Level
  );
`endif

endinterface

// File: rtl/hdmi_feed_fifo.sv
// Single-clock first-word-fall-through FIFO: block RAM plus a registered head word.
module hdmi_feed_fifo #(
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned WIDTH = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_next;
  logic [AW:0]      level_q;
  logic [WIDTH-1:0] head_q;

  assign rd_next = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= din;
  end

  // Head holds the entry at the next read pointer; bypass when that slot is written this cycle.
  always_ff @(posedge clk) begin
    head_q <= (push && (wr_ptr_q == rd_next)) ? din : mem[rd_next];
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push) level_q <= level_q - 1'b1;
    end
  end

  assign dout  = head_q;
  assign level = level_q;

endmodule

// File: rtl/hdmi_pixel_feeder.sv
// Pixel buffer in front of the HDMI transmitter: frame re-alignment on vsync, blank on underflow.
// Optional statistics counters are built when HDMI_FEED_STAT_EN is defined.
module hdmi_pixel_feeder
  import hdmi_feed_pkg::*;
#(
  parameter int unsigned       FIFO_DEPTH  = 2048,
  parameter int unsigned       FILL_LEVEL  = 1024,
  parameter logic [PIX_W-1:0]  BLANK_COLOR = 24'h000000
) (
  input  logic               Pixl_CLK,
  input  logic               Rst_Posedge,
  hdmi_pixel_feeder_if.slave bus
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  feed_state_e      state_q, state_d;
  logic             vs_d;
  logic             vs_rise;
  logic             ready;
  logic             push;
  logic             pop;
  logic             clear;
  logic             underflow;
  logic [PIX_W-1:0] head;
  logic [LW-1:0]    level;

  // vs_d resets high so a sync already asserted out of reset is not taken as an edge.
  always_ff @(posedge Pixl_CLK) begin
    if (Rst_Posedge) vs_d <= 1'b1;
    else             vs_d <= bus.I_VGA_Sync;
  end

  assign vs_rise = bus.I_VGA_Sync & ~vs_d;

  always_ff @(posedge Pixl_CLK) begin
    if (Rst_Posedge) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (vs_rise) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        clear   = 1'b1;
        state_d = S_FILL;
      end
      S_FILL: begin
        ready = (level < LW'(FIFO_DEPTH));
        if (vs_rise)                        state_d = S_FLUSH;
        else if (level >= LW'(FILL_LEVEL))  state_d = S_RUN;
      end
      S_RUN: begin
        ready = (level < LW'(FIFO_DEPTH));
        if (vs_rise) state_d = S_FLUSH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign push      = bus.I_Up_Valid & ready;
  assign pop       = bus.I_Pixel_Active & (state_q == S_RUN) & (level != '0);
  assign underflow = bus.I_Pixel_Active & (state_q != S_IDLE) & ~pop;

  hdmi_feed_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .clk   (Pixl_CLK),
    .rst   (Rst_Posedge),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .din   (bus.I_Up_Data),
    .dout  (head),
    .level (level)
  );

  assign bus.O_Up_Ready   = ready;
  assign bus.O_Frame_Req  = (state_q == S_FLUSH);
  assign bus.O_Pixel_Data = pop ? head : BLANK_COLOR;
  assign bus.O_Underflow  = underflow;
  assign bus.O_Fifo_Level = level;

`ifdef HDMI_FEED_STAT_EN
  logic [STAT_W-1:0] und_cnt_q;
  logic [STAT_W-1:0] frame_cnt_q;

  always_ff @(posedge Pixl_CLK) begin
    if (Rst_Posedge) begin
      und_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (state_q == S_FLUSH)             und_cnt_q <= '0;
      else if (underflow && !(&und_cnt_q)) und_cnt_q <= und_cnt_q + 1'b1;
      if (state_q != S_FLUSH && state_d == S_FLUSH) frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  assign bus.O_Underflow_Cnt = und_cnt_q;
  assign bus.O_Frame_Cnt     = frame_cnt_q;
`endif

endmodule

// File: tb/tb_hdmi_pixel_feeder.sv
// Randomized scoreboard bench for hdmi_pixel_feeder against a queue-based reference model.
module tb_hdmi_pixel_feeder;
  import hdmi_feed_pkg::*;

  localparam int unsigned DEPTH = 2048;
  localparam int unsigned FILL  = 1024;
  localparam logic [23:0] BLANK = 24'h000000;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hdmi_pixel_feeder_if #(.FIFO_DEPTH(DEPTH)) bus ();

  hdmi_pixel_feeder #(
    .FIFO_DEPTH  (DEPTH),
    .FILL_LEVEL  (FILL),
    .BLANK_COLOR (BLANK)
  ) dut (
    .Pixl_CLK    (clk),
    .Rst_Posedge (rst),
    .bus         (bus)
  );

  typedef enum int {M_IDLE, M_FLUSH, M_FILL, M_RUN} mode_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [23:0] q[$];
  mode_t       mode = M_IDLE;
  mode_t       next_mode;
  bit          vs_prev = 1'b1;
  bit          started = 1'b0;
  bit          m_push = 1'b0;
  int          und_seen = 0;
  int          req_seen = 0;
  int          max_level = 0;
  int          lvl;
  bit          vs_rise, e_ready, e_req, e_under, e_pop;
  logic [15:0] m_und_cnt = '0;
  logic [15:0] m_frame_cnt = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor + reference model: evaluates each cycle between clock edges.
  always @(negedge clk) begin
    if (rst) begin
      started     = 1'b1;
      mode        = M_IDLE;
      q.delete();
      vs_prev     = 1'b1;
      m_push      = 1'b0;
      m_und_cnt   = '0;
      m_frame_cnt = '0;
    end else if (started) begin
      lvl     = q.size();
      vs_rise = bus.I_VGA_Sync && !vs_prev;
      e_ready = (mode == M_FILL || mode == M_RUN) && lvl < DEPTH;
      e_req   = (mode == M_FLUSH);
      e_pop   = (mode == M_RUN) && bus.I_Pixel_Active && lvl > 0;
      e_under = bus.I_Pixel_Active && mode != M_IDLE && !e_pop;
      check("ctrl{ready,req,under,level}",
            {bus.O_Up_Ready, bus.O_Frame_Req, bus.O_Underflow, bus.O_Fifo_Level},
            {e_ready, e_req, e_under, LW'(lvl)});
      if (e_pop) begin
        check("pixel", bus.O_Pixel_Data, q[0]);
        void'(q.pop_front());
      end else begin
        check("blank", bus.O_Pixel_Data, BLANK);
      end
`ifdef HDMI_FEED_STAT_EN
      check("und_cnt", bus.O_Underflow_Cnt, m_und_cnt);
      check("frame_cnt", bus.O_Frame_Cnt, m_frame_cnt);
`endif
      if (bus.O_Underflow) und_seen++;
      if (bus.O_Frame_Req) req_seen++;
      if (int'(bus.O_Fifo_Level) > max_level) max_level = int'(bus.O_Fifo_Level);
      m_push = bus.I_Up_Valid && e_ready;
      if (m_push) q.push_back(bus.I_Up_Data);
      next_mode = mode;
      if (mode == M_FLUSH) begin
        q.delete();
        next_mode = M_FILL;
      end else if (vs_rise) begin
        next_mode = M_FLUSH;
      end else if (mode == M_FILL && lvl >= FILL) begin
        next_mode = M_RUN;
      end
      if (mode == M_FLUSH) m_und_cnt = '0;
      else if (e_under && m_und_cnt != 16'hFFFF) m_und_cnt++;
      if (next_mode == M_FLUSH && mode != M_FLUSH) m_frame_cnt++;
      mode    = next_mode;
      vs_prev = bus.I_VGA_Sync;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vsync_pulse();
    bus.I_VGA_Sync = 1'b1;
    tick();
    bus.I_VGA_Sync = 1'b0;
  endtask

  task automatic fill_to_run();
    bus.I_Up_Valid = 1'b1;
    for (int c = 0; c < 5000 && mode != M_RUN; c++) begin
      bus.I_Up_Data = 24'($urandom);
      tick();
    end
  endtask

  int ramp;
  int act_left;

  initial begin
    bus.I_Up_Data      = '0;
    bus.I_Up_Valid     = 1'b0;
    bus.I_Pixel_Active = 1'b0;
    bus.I_VGA_Sync     = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Idle after reset: strobes must not underflow or accept.
    und_seen = 0;
    bus.I_Pixel_Active = 1'b1;
    repeat (10) tick();
    bus.I_Pixel_Active = 1'b0;
    check("t1_underflow_count", und_seen, 0);
    check("t1_ready", bus.O_Up_Ready, 1'b0);
    check("t1_level", bus.O_Fifo_Level, 0);

    // Continuous 1920-pixel ramp, consumed once the fill level is reached.
    req_seen = 0;
    und_seen = 0;
    vsync_pulse();
    ramp     = 0;
    act_left = 1920;
    for (int c = 0; c < 20000 && (ramp < 1920 || act_left > 0); c++) begin
      bus.I_Up_Valid     = (ramp < 1920);
      bus.I_Up_Data      = 24'(ramp);
      bus.I_Pixel_Active = (mode == M_RUN) && act_left > 0;
      if (bus.I_Pixel_Active) act_left--;
      tick();
      if (m_push) ramp++;
    end
    bus.I_Up_Valid     = 1'b0;
    bus.I_Pixel_Active = 1'b0;
    tick();
    check("t2_ramp_pushed", ramp, 1920);
    check("t2_underflow_count", und_seen, 0);
    check("t2_frame_req_pulses", req_seen, 1);

    // Overfill: 2100 offered pixels, no pops.
    vsync_pulse();
    max_level = 0;
    bus.I_Up_Valid = 1'b1;
    repeat (2100) begin
      bus.I_Up_Data = 24'($urandom);
      tick();
    end
    bus.I_Up_Valid = 1'b0;
    check("t3_max_level", max_level, DEPTH);
    check("t3_ready_when_full", bus.O_Up_Ready, 1'b0);

    // Drain to 100 entries, then 150 strobes: last 50 underflow.
    bus.I_Pixel_Active = 1'b1;
    repeat (1948) tick();
    check("t4_level_100", bus.O_Fifo_Level, 100);
    und_seen = 0;
    repeat (150) tick();
    bus.I_Pixel_Active = 1'b0;
    check("t4_underflow_count", und_seen, 50);
`ifdef HDMI_FEED_STAT_EN
    check("t4_underflow_cnt_port", bus.O_Underflow_Cnt, 50);
`endif

    // Mid-frame resync at level 500.
    vsync_pulse();
    fill_to_run();
    bus.I_Up_Valid     = 1'b0;
    bus.I_Pixel_Active = 1'b1;
    for (int c = 0; c < 5000 && q.size() > 500; c++) tick();
    check("t5_level_500", bus.O_Fifo_Level, 500);
    bus.I_VGA_Sync = 1'b1;
    bus.I_Up_Valid = 1'(($urandom & 1));
    tick();
    bus.I_VGA_Sync = 1'b0;
    check("t5_frame_req_n1", bus.O_Frame_Req, 1'b1);
    tick();
    check("t5_level_n2", bus.O_Fifo_Level, 0);
    und_seen = 0;
    repeat (400) begin
      bus.I_Up_Valid = 1'(($urandom & 1));
      bus.I_Up_Data  = 24'($urandom);
      tick();
    end
    check("t5_blank_underflows", und_seen, 400);

    // Randomized traffic with occasional resyncs.
    repeat (6000) begin
      bus.I_Up_Valid     = ($urandom_range(0, 3) != 0);
      bus.I_Up_Data      = 24'($urandom);
      bus.I_Pixel_Active = 1'(($urandom & 1));
      bus.I_VGA_Sync     = ($urandom_range(0, 1499) == 0);
      tick();
    end
    bus.I_VGA_Sync = 1'b0;
    tick();

    // Reset during RUN with simultaneous push and pop.
    vsync_pulse();
    fill_to_run();
    bus.I_Pixel_Active = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t6_ready", bus.O_Up_Ready, 1'b0);
    check("t6_frame_req", bus.O_Frame_Req, 1'b0);
    check("t6_underflow", bus.O_Underflow, 1'b0);
    check("t6_pixel", bus.O_Pixel_Data, BLANK);
    check("t6_level", bus.O_Fifo_Level, 0);
    repeat (3) tick();
    bus.I_Up_Valid     = 1'b0;
    bus.I_Pixel_Active = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
